// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: op codes, NZCV flag indices, FSM states.
// Pure declarations; no latency or backpressure of its own.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_ORR  = 3'b011,
      OP_EOR  = 3'b100,
      OP_MVN  = 3'b101,
      OP_MUL  = 3'b110,
      OP_RSVD = 3'b111
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   // Only ADD and SUB produce meaningful carry and overflow.
   function automatic logic is_arith(alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle between the execute-stage sequencer (master) and alu_mc (slave).
// Valid/ready on the request side only; results are a one-cycle out_valid pulse with no backpressure.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   alu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             set_flags;
   logic             out_valid;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       flags;
   logic             busy;

   modport master (
      output in_valid, op, a, b, set_flags,
      input  in_ready, out_valid, out_result, flags, busy
   );

   modport slave (
      input  in_valid, op, a, b, set_flags,
      output in_ready, out_valid, out_result, flags, busy
   );

endinterface

// File: rtl/alu_mc_mul_iter.sv
// Iterative unsigned shift-add multiplier, one bit of b per cycle LSB first; low WIDTH product bits.
// Latency: iteration 0 runs on the start edge, done is raised WIDTH-1 cycles later; start is never refused.
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt;
   logic             run;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] partial;

   assign partial = mplier[0] ? mcand : '0;
   // The final iteration is folded combinationally into product so the caller can register it directly.
   assign done    = run && (cnt == CW'(WIDTH - 1));
   assign product = acc + partial;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         run    <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         acc    <= b[0] ? a : '0;
         mcand  <= a << 1;
         mplier <= b >> 1;
         cnt    <= CW'(1);
         run    <= 1'b1;
      end else if (run) begin
         acc    <= acc + partial;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            run <= 1'b0;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU with ARM-style NZCV flags register; single-cycle ops plus iterative MUL.
// Latency 1 cycle (MUL: WIDTH cycles); in_ready drops while MUL iterates, results never backpressured.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic    clk,
   input  logic    rst_n,
   alu_mc_if.slave bus
);

   localparam int MSB = WIDTH - 1;

   state_e           state;
   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic             mul_sf;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] sum_b;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             add_c;
   logic             add_v;

   assign bus.in_ready = (state == IDLE);
   assign bus.busy     = (state == MUL);
   assign accept       = bus.in_valid && bus.in_ready;
   assign mul_start    = accept && (bus.op == OP_MUL);

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done),
      .product (mul_product)
   );

   // SUB reuses the adder as a + ~b + 1, so carry out is the ARM no-borrow flag.
   always_comb begin
      sum_b = bus.b;
      cin   = 1'b0;
      if (bus.op == OP_SUB) begin
         sum_b = ~bus.b;
         cin   = 1'b1;
      end
      sum   = {1'b0, bus.a} + {1'b0, sum_b} + {{WIDTH{1'b0}}, cin};
      add_c = sum[WIDTH];
      add_v = (bus.a[MSB] == sum_b[MSB]) && (sum[MSB] != bus.a[MSB]);
      res   = '0;
      case (bus.op)
         OP_ADD, OP_SUB: res = sum[MSB:0];
         OP_AND:         res = bus.a & bus.b;
         OP_ORR:         res = bus.a | bus.b;
         OP_EOR:         res = bus.a ^ bus.b;
         OP_MVN:         res = ~bus.a;
         default:        res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         mul_sf         <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.flags      <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.op == OP_MUL) begin
                     state  <= MUL;
                     mul_sf <= bus.set_flags;
                  end else begin
                     bus.out_valid  <= 1'b1;
                     bus.out_result <= res;
                     if (bus.set_flags && (bus.op != OP_RSVD)) begin
                        bus.flags[FLAG_N] <= res[MSB];
                        bus.flags[FLAG_Z] <= (res == '0);
                        if (is_arith(bus.op)) begin
                           bus.flags[FLAG_C] <= add_c;
                           bus.flags[FLAG_V] <= add_v;
                        end
                     end
                  end
               end
            end
            MUL: begin
               if (mul_done) begin
                  state          <= IDLE;
                  bus.out_valid  <= 1'b1;
                  bus.out_result <= mul_product;
                  if (mul_sf) begin
                     bus.flags[FLAG_N] <= mul_product[MSB];
                     bus.flags[FLAG_Z] <= (mul_product == '0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
